centroid_div_sched: RTL

- Time-shares one sequential restoring divider between the two division consumers of the red-blob centroid pipeline.
- Port A is the per-line requester: column average = column-sum / red-pixel count, issued once per 640-pixel line.
- Port B is the per-frame requester: row average = row-sum / active-row count, issued once per frame.
- Replaces wide combinational dividers. Fixed latency per operation; A has priority; B is protected from starvation.

---
 rtl/centroid_div_sched_if.sv | 35 +++
 rtl/centroid_div_sched.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/centroid_div_sched_if.sv
// Handshake and operand bundle for the shared centroid divider.
// Port A is the per-line column-average requester; port B is the per-frame
// row-average requester. The slave modport is the divider side.
interface centroid_div_sched_if #(
  parameter int DVD_W = 19,
  parameter int DVS_W = 10
);
  // Port A: request level is held until oA_DONE.
  logic             iA_REQ;
  logic [DVD_W-1:0] iA_DVD;
  logic [DVS_W-1:0] iA_DVS;
  logic [DVD_W-1:0] oA_QUO;
  logic [DVS_W-1:0] oA_REM;
  logic             oA_DONE;
  // Port B: request level is held until oB_DONE.
  logic             iB_REQ;
  logic [DVD_W-1:0] iB_DVD;
  logic [DVS_W-1:0] iB_DVS;
  logic [DVD_W-1:0] oB_QUO;
  logic [DVS_W-1:0] oB_REM;
  logic             oB_DONE;
  // Shared status.
  logic             oBUSY;
  logic             oOWNER;

  modport master (
    output iA_REQ, iA_DVD, iA_DVS, iB_REQ, iB_DVD, iB_DVS,
    input  oA_QUO, oA_REM, oA_DONE, oB_QUO, oB_REM, oB_DONE, oBUSY, oOWNER
  );

  modport slave (
    input  iA_REQ, iA_DVD, iA_DVS, iB_REQ, iB_DVD, iB_DVS,
    output oA_QUO, oA_REM, oA_DONE, oB_QUO, oB_REM, oB_DONE, oBUSY, oOWNER
  );
endinterface

// File: rtl/centroid_div_sched.sv
// Shares one MSB-first restoring divider between port A (per-line) and port B (per-frame).
// Latency: request sampled in IDLE at cycle t -> DONE pulse at t+DVD_W+1; one result per DVD_W+2 cycles.
// Backpressure: requests are level-held and wait in IDLE; A has priority, B wins after MAX_A_STREAK A grants.
// Ports: iCLK clock, iRST async active-low reset, bus = slave side of centroid_div_sched_if
//   (REQ/DVD/DVS per port in; QUO/REM/DONE per port out; BUSY and OWNER status out).
module centroid_div_sched #(
  parameter int DVD_W        = 19,
  parameter int DVS_W        = 10,
  parameter int MAX_A_STREAK = 2
) (
  input logic                  iCLK,
  input logic                  iRST,
  centroid_div_sched_if.slave  bus
);

  localparam int CNT_W  = $clog2(DVD_W);
  localparam int STRK_W = $clog2(MAX_A_STREAK + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic                grant_a, grant_b;
  logic [STRK_W-1:0]   streak_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                owner_q;
  // Dividend shift register; quotient bits are shifted in from the LSB end
  // as dividend bits leave the MSB end, so it ends up holding the quotient.
  logic [DVD_W-1:0]    dvd_q;
  logic [DVS_W-1:0]    dvs_q;
  logic [DVS_W:0]      rem_q;

  logic [DVS_W:0]      shifted, diff, rem_n;
  logic                q_bit;
  logic [DVD_W-1:0]    quo_n;
  logic [DVD_W-1:0]    fin_quo;
  logic [DVS_W-1:0]    fin_rem;
  logic                unused_rem_msb;

  logic [DVD_W-1:0]    a_quo_q, b_quo_q;
  logic [DVS_W-1:0]    a_rem_q, b_rem_q;
  logic                a_done_q, b_done_q;

  // The partial remainder stays below a nonzero divisor, so its MSB is only
  // ever set in the divide-by-zero case, whose result is overridden anyway.
  assign unused_rem_msb = rem_q[DVS_W];

  // One restoring iteration.
  always_comb begin
    shifted = {rem_q[DVS_W-1:0], dvd_q[DVD_W-1]};
    q_bit   = (shifted >= {1'b0, dvs_q});
    diff    = shifted - {1'b0, dvs_q};
    rem_n   = q_bit ? diff : shifted;
    quo_n   = {dvd_q[DVD_W-2:0], q_bit};
    fin_quo = (dvs_q == '0) ? '1 : quo_n;
    fin_rem = (dvs_q == '0) ? '0 : rem_n[DVS_W-1:0];
  end

  // Next-state and arbitration.
  always_comb begin
    state_d = state_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.iA_REQ && !(bus.iB_REQ && streak_q == STRK_W'(MAX_A_STREAK))) begin
          grant_a = 1'b1;
          state_d = RUN;
        end else if (bus.iB_REQ) begin
          grant_b = 1'b1;
          state_d = RUN;
        end
      end
      RUN:     if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      streak_q <= '0;
      cnt_q    <= '0;
      owner_q  <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      a_quo_q  <= '0;
      a_rem_q  <= '0;
      b_quo_q  <= '0;
      b_rem_q  <= '0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
    end else begin
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      if (grant_a) begin
        dvd_q   <= bus.iA_DVD;
        dvs_q   <= bus.iA_DVS;
        owner_q <= 1'b0;
        // Only A grants that actually held B off count toward the streak.
        if (!bus.iB_REQ)                               streak_q <= '0;
        else if (streak_q != STRK_W'(MAX_A_STREAK))   streak_q <= streak_q + 1'b1;
      end
      if (grant_b) begin
        dvd_q    <= bus.iB_DVD;
        dvs_q    <= bus.iB_DVS;
        owner_q  <= 1'b1;
        streak_q <= '0;
      end
      if (grant_a || grant_b) begin
        rem_q <= '0;
        cnt_q <= CNT_W'(DVD_W - 1);
      end
      if (state_q == RUN) begin
        dvd_q <= quo_n;
        rem_q <= rem_n;
        cnt_q <= cnt_q - 1'b1;
        // Results are registered on the last iteration so they are already
        // valid while the owner's DONE pulse is high in the DONE state.
        if (cnt_q == '0) begin
          if (owner_q) begin
            b_quo_q  <= fin_quo;
            b_rem_q  <= fin_rem;
            b_done_q <= 1'b1;
          end else begin
            a_quo_q  <= fin_quo;
            a_rem_q  <= fin_rem;
            a_done_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.oA_QUO  = a_quo_q;
  assign bus.oA_REM  = a_rem_q;
  assign bus.oA_DONE = a_done_q;
  assign bus.oB_QUO  = b_quo_q;
  assign bus.oB_REM  = b_rem_q;
  assign bus.oB_DONE = b_done_q;
  assign bus.oBUSY   = (state_q != IDLE);
  assign bus.oOWNER  = owner_q;

endmodule
